// File: rtl/act_vec_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : act_pkg
//  Description : Shared types and elaboration-time helpers for the activation
//                vector feeder: FSM state encoding, beat count and beat-counter
//                width derivation, and lane bit-slice positioning.
//  Revision    : 1.0 - initial release
// ============================================================================
package act_pkg;

    // Feeder states: collecting beats, or sitting on a complete vector
    // waiting for the vector engine to allow issue.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of input beats that make up one full vector.
    function automatic int calc_beats(input int bus_num, input int in_lanes);
        return bus_num / in_lanes;
    endfunction

    // Beat counter width; a single-beat vector still needs a 1-bit counter.
    function automatic int calc_beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Least-significant bit position of a lane inside a packed lane vector.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_vec_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : act_vec_feeder_if
//  Description : Bundle between the SRAM/accumulator read path, the vector
//                engine controller and the activation feeder.
//                master : beat source / controller side
//                slave  : feeder side
//  Signals     : in_data, in_valid, in_last, in_ready   beat handshake
//                act_en                                 issue permission
//                out_fixed_data, out_fixed_data_vld     issued vector + mask
//                vec_cnt, busy                          status
//  Revision    : 1.0 - initial release
// ============================================================================
interface act_vec_feeder_if #(
    parameter int BUS_NUM          = 16,
    parameter int IN_LANES         = 4,
    parameter int FIXED_DATA_WIDTH = 8,
    parameter int CNT_WIDTH        = 16
);
    logic [IN_LANES*FIXED_DATA_WIDTH-1:0] in_data;
    logic                                 in_valid;
    logic                                 in_last;
    logic                                 in_ready;
    logic                                 act_en;
    logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]  out_fixed_data;
    logic [BUS_NUM-1:0]                   out_fixed_data_vld;
    logic [CNT_WIDTH-1:0]                 vec_cnt;
    logic                                 busy;

    modport master (
        output in_data, in_valid, in_last, act_en,
        input  in_ready, out_fixed_data, out_fixed_data_vld, vec_cnt, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, act_en,
        output in_ready, out_fixed_data, out_fixed_data_vld, vec_cnt, busy
    );

endinterface
`default_nettype wire

// File: rtl/act_vec_feeder_beat_mask.sv
`default_nettype none
// ============================================================================
//  Module      : act_beat_mask
//  Description : Converts the current beat index into the BUS_NUM-bit lane
//                mask slice that the beat occupies, and produces the
//                cumulative lane mask after the beat (if accepted). The
//                cumulative mask decides which lanes carry data and which
//                are zero-filled on issue.
//  Ports       : beat_cnt   in   beat index within the vector
//                accept     in   beat is being accepted this cycle
//                cur_mask   in   lanes already collected
//                set_mask   out  lanes owned by beat_cnt (ungated)
//                next_mask  out  cur_mask plus this beat when accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module act_beat_mask #(
    parameter int BUS_NUM  = 16,
    parameter int IN_LANES = 4,
    parameter int BCW      = 2
) (
    input  wire logic [BCW-1:0]     beat_cnt,
    input  wire logic               accept,
    input  wire logic [BUS_NUM-1:0] cur_mask,
    output logic      [BUS_NUM-1:0] set_mask,
    output logic      [BUS_NUM-1:0] next_mask
);

    localparam int BEATS = BUS_NUM / IN_LANES;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat_slice
        assign set_mask[b*IN_LANES +: IN_LANES] =
            (beat_cnt == BCW'(b)) ? {IN_LANES{1'b1}} : {IN_LANES{1'b0}};
    end

    assign next_mask = accept ? (cur_mask | set_mask) : cur_mask;

endmodule
`default_nettype wire

// File: rtl/act_vec_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : act_vec_feeder
//  Description : Transmit side of the vector-engine activation interface.
//                Collects IN_LANES-wide signed beats into a BUS_NUM-lane
//                vector and issues it as a one-cycle pulse with a per-lane
//                valid mask. Short vectors end early on in_last; a completed
//                vector is held while act_en is low.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                bus (slave modport)      beat handshake, act_en, issued
//                                         vector, mask, vec_cnt, busy
//  Revision    : 1.0 - initial release
// ============================================================================
module act_vec_feeder
    import act_pkg::*;
#(
    parameter int BUS_NUM          = 16,
    parameter int IN_LANES         = 4,
    parameter int FIXED_DATA_WIDTH = 8,
    parameter int CNT_WIDTH        = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    act_vec_feeder_if.slave  bus
);

    localparam int             BEATS     = calc_beats(BUS_NUM, IN_LANES);
    localparam int             BCW       = calc_beat_cnt_w(BEATS);
    localparam int             W         = FIXED_DATA_WIDTH;
    localparam int             BEAT_W    = IN_LANES * W;
    localparam int             VEC_W     = BUS_NUM * W;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [BCW-1:0]       r_beat_cnt;
    logic [BUS_NUM-1:0]   r_mask;
    logic [VEC_W-1:0]     r_buf;
    logic [VEC_W-1:0]     r_out_data;
    logic [BUS_NUM-1:0]   r_out_vld;
    logic [CNT_WIDTH-1:0] r_vec_cnt;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_issue;
    logic [BUS_NUM-1:0]   w_set_mask;
    logic [BUS_NUM-1:0]   w_mask_next;
    logic [VEC_W-1:0]     w_buf_next;
    logic [VEC_W-1:0]     w_issue_data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_complete && !bus.act_en) w_state_next = HOLD;
            HOLD:    if (bus.act_en)                w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready = !rst && (r_state == FILL);
        w_accept   = bus.in_valid && w_in_ready;
        // in_last only matters on an accepted beat, so a stray in_last with
        // in_valid low cannot close a vector.
        w_complete = w_accept && ((r_beat_cnt == LAST_BEAT) || bus.in_last);
        w_issue    = 1'b0;
        case (r_state)
            FILL:    w_issue = w_complete && bus.act_en;
            HOLD:    w_issue = bus.act_en;
            default: w_issue = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane mask bookkeeping
    // ------------------------------------------------------------------
    act_beat_mask #(
        .BUS_NUM  (BUS_NUM),
        .IN_LANES (IN_LANES),
        .BCW      (BCW)
    ) u_beat_mask (
        .beat_cnt  (r_beat_cnt),
        .accept    (w_accept),
        .cur_mask  (r_mask),
        .set_mask  (w_set_mask),
        .next_mask (w_mask_next)
    );

    // Buffer view including the beat accepted this cycle, so a completing
    // beat can be issued at the same edge it is accepted.
    for (genvar b = 0; b < BEATS; b++) begin : g_buf_slot
        assign w_buf_next[b*BEAT_W +: BEAT_W] =
            (w_accept && w_set_mask[b*IN_LANES]) ? bus.in_data
                                                 : r_buf[b*BEAT_W +: BEAT_W];
    end

    // Lanes never written for this vector may hold stale data from an
    // earlier one; they are forced to zero on issue.
    for (genvar k = 0; k < BUS_NUM; k++) begin : g_lane_fill
        assign w_issue_data[lane_lsb(k, W) +: W] =
            w_mask_next[k] ? w_buf_next[lane_lsb(k, W) +: W] : {W{1'b0}};
    end

    // ------------------------------------------------------------------
    // Assembly buffer, output registers and vector counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_mask     <= '0;
            r_buf      <= '0;
            r_out_data <= '0;
            r_out_vld  <= '0;
            r_vec_cnt  <= '0;
        end else begin
            r_out_data <= '0;
            r_out_vld  <= '0;
            if (w_issue) begin
                r_out_data <= w_issue_data;
                r_out_vld  <= w_mask_next;
                r_vec_cnt  <= r_vec_cnt + 1'b1;
                r_beat_cnt <= '0;
                r_mask     <= '0;
                r_buf      <= w_buf_next;
            end else if (w_accept) begin
                r_buf      <= w_buf_next;
                r_mask     <= w_mask_next;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready           = w_in_ready;
    assign bus.out_fixed_data     = r_out_data;
    assign bus.out_fixed_data_vld = r_out_vld;
    assign bus.vec_cnt            = r_vec_cnt;
    assign bus.busy               = (r_mask != '0) || (r_state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_act_vec_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_act_vec_feeder
//  Description : Self-checking bench for act_vec_feeder. A lane-queue model
//                predicts in_ready, the issued vector, its mask, vec_cnt and
//                busy every cycle; each scenario task compares inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_act_vec_feeder;

    localparam int BUS = 16;
    localparam int IL  = 4;
    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int BW  = 2 + CW + BUS + BUS * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    act_vec_feeder_if #(
        .BUS_NUM(BUS), .IN_LANES(IL), .FIXED_DATA_WIDTH(W), .CNT_WIDTH(CW)
    ) bus ();

    act_vec_feeder #(
        .BUS_NUM(BUS), .IN_LANES(IL), .FIXED_DATA_WIDTH(W), .CNT_WIDTH(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: lanes collected so far for the open vector.
    logic [W-1:0]     col[$];
    bit               holding;
    logic [BUS*W-1:0] exp_data;
    logic [BUS-1:0]   exp_vld;
    logic [CW-1:0]    exp_cnt;
    logic             exp_busy;
    logic             exp_ready;

    logic [BUS*W-1:0] obs_data;
    logic [BUS-1:0]   obs_vld;
    logic [CW-1:0]    obs_cnt;
    logic             obs_busy;
    logic             obs_ready;

    function automatic logic [BW-1:0] obs_bundle();
        return {obs_ready, obs_busy, obs_cnt, obs_vld, obs_data};
    endfunction

    function automatic logic [BW-1:0] exp_bundle();
        return {exp_ready, exp_busy, exp_cnt, exp_vld, exp_data};
    endfunction

    task automatic drive(input bit v, input bit l, input logic [IL*W-1:0] d, input bit e);
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
        bus.act_en   = e;
    endtask

    // One clock: sample in_ready before the edge, advance the model at the
    // edge, sample registered outputs just after it.
    task automatic tick();
        bit issue;
        @(negedge clk);
        obs_ready = bus.in_ready;
        exp_ready = !rst && !holding;
        @(posedge clk);
        issue    = 1'b0;
        exp_data = '0;
        exp_vld  = '0;
        if (rst) begin
            col.delete();
            holding = 1'b0;
            exp_cnt = '0;
        end else if (holding) begin
            if (bus.act_en) issue = 1'b1;
        end else if (bus.in_valid) begin
            for (int j = 0; j < IL; j++) col.push_back(bus.in_data[j*W +: W]);
            if (col.size() == BUS || bus.in_last) begin
                if (bus.act_en) issue = 1'b1;
                else            holding = 1'b1;
            end
        end
        if (issue) begin
            for (int k = 0; k < col.size(); k++) begin
                exp_data[k*W +: W] = col[k];
                exp_vld[k]         = 1'b1;
            end
            exp_cnt = exp_cnt + 1'b1;
            col.delete();
            holding = 1'b0;
        end
        exp_busy = (col.size() != 0) || holding;
        #1;
        obs_data = bus.out_fixed_data;
        obs_vld  = bus.out_fixed_data_vld;
        obs_cnt  = bus.vec_cnt;
        obs_busy = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs_bundle(), exp_bundle());
            end
        end
    endtask

    task automatic test_full_vector();
        for (int b = 0; b < 5; b++) begin
            if (b < 4) drive(1'b1, 1'b0, {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, 1'b1);
            else       drive(1'b0, 1'b0, '0, 1'b1);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL full_vector cyc=%0d got=%h exp=%h", b, obs_bundle(), exp_bundle());
            end
            if (b == 3) begin
                checks++;
                if (obs_data !== 128'h0f0e0d0c0b0a09080706050403020100 || obs_vld !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL full_vector_const got vld=%h data=%h exp vld=ffff ramp", obs_vld, obs_data);
                end
            end
        end
    endtask

    task automatic test_short_vector();
        for (int b = 0; b < 3; b++) begin
            if (b == 0)      drive(1'b1, 1'b0, 32'h84838281, 1'b1);
            else if (b == 1) drive(1'b1, 1'b1, 32'h88878685, 1'b1);
            else             drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL short_vector cyc=%0d got=%h exp=%h", b, obs_bundle(), exp_bundle());
            end
            if (b == 1) begin
                checks++;
                if (obs_vld !== 16'h00FF || obs_data !== 128'h0000000000000000_8887868584838281) begin
                    failures++;
                    $display("FAIL short_vector_const got vld=%h data=%h exp vld=00ff", obs_vld, obs_data);
                end
            end
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 11; c++) begin
            if (c < 4)       drive(1'b1, 1'b0, $urandom, 1'b0);
            else if (c < 9)  drive(1'b1, 1'b0, $urandom, 1'b0);
            else if (c == 9) drive(1'b1, 1'b0, $urandom, 1'b1);
            else             drive(1'b0, 1'b0, '0, 1'b0);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs_bundle(), exp_bundle());
            end
            if (c >= 4 && c <= 9) begin
                checks++;
                if (obs_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_ready cyc=%0d got=%b exp=0", c, obs_ready);
                end
            end
        end
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 13; c++) begin
            if (c < 12) drive(1'b1, 1'b0, $urandom, 1'b1);
            else        drive(1'b0, 1'b0, '0, 1'b1);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL streaming cyc=%0d got=%h exp=%h", c, obs_bundle(), exp_bundle());
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int c = 0; c < 8; c++) begin
            rst = (c == 2);
            if (c == 2 || c == 7) drive(1'b0, 1'b0, '0, 1'b1);
            else                  drive(1'b1, 1'b0, $urandom, 1'b1);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL reset_mid_fill cyc=%0d got=%h exp=%h", c, obs_bundle(), exp_bundle());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  $urandom, $urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_bundle(), exp_bundle());
            end
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_wrap();
        int  n;
        bit  reached;
        reached = 1'b0;
        n = 0;
        while (!reached && n < 70000) begin
            drive(1'b1, 1'b1, $urandom, 1'b1);
            tick();
            n++;
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL wrap_run cyc=%0d got=%h exp=%h", n, obs_bundle(), exp_bundle());
            end
            if (exp_cnt == 16'hFFFF) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL wrap_budget got cnt=%h exp=ffff within 70000 cycles", obs_cnt);
        end
        drive(1'b1, 1'b1, 32'h7F80017F, 1'b1);
        tick();
        checks++;
        if (obs_cnt !== 16'h0000 || obs_vld !== 16'h000F) begin
            failures++;
            $display("FAIL wrap got cnt=%h vld=%h exp cnt=0000 vld=000f", obs_cnt, obs_vld);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        checks++;
        if (obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL wrap_idle got=%h exp=%h", obs_bundle(), exp_bundle());
        end
    endtask

    initial begin
        holding = 1'b0;
        exp_cnt = '0;
        test_reset();
        test_full_vector();
        test_short_vector();
        test_hold();
        test_streaming();
        test_reset_mid_fill();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/act_vec_feeder.md
Name: act_vec_feeder

Overview:
- Transmit side of the vector-engine activation interface.
- Accepts narrow beats of IN_LANES signed fixed-point lanes from the SRAM/accumulator read path over a valid/ready handshake.
- Assembles them into one BUS_NUM-lane vector and issues it for a single cycle with a per-lane valid mask, in the form the activation units consume (e.g. silu).
- Supports short final vectors via in_last, and holds a completed vector while the vector engine disables issue.

Parameters:
- BUS_NUM, 16: lanes per issued vector; must be a multiple of IN_LANES.
- IN_LANES, 4: lanes per input beat.
- FIXED_DATA_WIDTH, 8: bits per lane, signed.
- CNT_WIDTH, 16: width of the issued-vector counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_LANES*FIXED_DATA_WIDTH  beat payload; lane j is at bits j*W +: W.
- in_valid  in  1  beat valid.
- in_last  in  1  final beat of the current vector; qualified by in_valid.
- in_ready  out  1  feeder can accept a beat.
- act_en  in  1  issue permission from the vector-engine controller.
- out_fixed_data  out  BUS_NUM*FIXED_DATA_WIDTH  issued vector, signed lanes.
- out_fixed_data_vld  out  BUS_NUM  per-lane valid, one-cycle pulse.
- vec_cnt  out  CNT_WIDTH  count of vectors issued.
- busy  out  1  partial or held vector present.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_fixed_data=0, out_fixed_data_vld=0, vec_cnt=0, busy=0, state=FILL, beat_cnt=0, assembly mask=0.
- Reset mid-operation: any partial or held vector is discarded with no issue.
- BEATS = BUS_NUM/IN_LANES. Lane index of beat b, lane j = b*IN_LANES+j.
- in_ready = !rst && state==FILL (combinational). Accept = in_valid && in_ready.
- FILL state:
  - Each accept writes the beat into the assembly buffer at beat_cnt and sets the corresponding IN_LANES mask bits.
  - beat_cnt increments on each accept.
  - A beat completes the vector when beat_cnt==BEATS-1 or in_last=1.
- Completion with act_en=1 in the same cycle:
  - At that edge, the output registers load the assembled vector including the current beat.
  - Lanes whose mask bit is 0 are driven as 0 data.
  - out_fixed_data_vld = mask, so a short vector has a contiguous low-lane mask.
  - beat_cnt resets to 0, the mask clears, vec_cnt increments, and the state stays FILL.
  - Latency: vector visible 1 cycle after the completing accept. Back-to-back vectors need no bubble.
- Completion with act_en=0:
  - Go to HOLD. The buffer and mask are frozen and in_ready=0.
- HOLD state:
  - On a cycle with act_en=1, issue as above at that edge and return to FILL; in_ready rises in the following cycle.
  - in_valid is ignored while in HOLD.
- Non-issue cycles: out_fixed_data_vld=0 and out_fixed_data=0, matching the activation units, which zero invalid lanes.
- Every issue pulse lasts exactly 1 cycle; there is no downstream backpressure.
- act_en while no vector is complete has no effect.
- busy = (mask!=0) || state==HOLD.
- vec_cnt wraps modulo 2^CNT_WIDTH.
- in_last on beat 0 with in_valid issues a vector with only the low IN_LANES lanes valid.
- in_last is ignored when in_valid=0.
- in_data is not sign-modified; lanes are passed bit-exact.

Decomposition:
- Shared package act_pkg:
  - state enum {FILL, HOLD};
  - localparam function computing BEATS and the beat-counter width ($clog2(BEATS), minimum 1);
  - lane-slice helper constants.
- One sub-module, act_beat_mask: maps beat_cnt to the BUS_NUM-bit mask slice to set, and the cumulative mask to zero-fill unused lanes.
- The top level holds the FSM, assembly buffer, output registers and counter.

Test Plan (BUS_NUM=16, IN_LANES=4, W=8):
1. Full vector with act_en=1: 4 beats of bytes 0x00..0x0F back-to-back → one cycle after beat 3, out lane k = k, vld=16'hFFFF for 1 cycle, vec_cnt=1.
2. Short vector: 2 beats (lanes 0x81..0x88), in_last on beat 1 → vld=16'h00FF, lanes 0–7 = 0x81..0x88, lanes 8–15 = 0.
3. Hold: act_en=0 at completion → in_ready=0 and vld=0 for 5 cycles while in_valid stays high. Raise act_en → one issue pulse at the next edge with data intact, in_ready=1 the following cycle.
4. Streaming: 3 vectors with continuous valid and act_en=1 → vld pulses every 4 cycles, no stall, vec_cnt=3.
5. Reset mid-fill: after 2 beats, pulse rst 1 cycle → outputs 0, busy=0. Then 4 new beats → vector contains only the new data.
6. Wrap: preload vec_cnt to 0xFFFF by issuing vectors (or force) → the next issue gives vec_cnt=0.
